// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, reset-cause
// codes, parameter defaults and the counter-width helper.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    StAssert,
    StRelease,
    StRun,
    StQuiesce
  } state_e;

  typedef enum logic [1:0] {
    CauseSys         = 2'b00,
    CauseUserAck     = 2'b01,
    CauseUserTimeout = 2'b10
  } cause_e;

  localparam int unsigned DefNDom     = 3;
  localparam int unsigned DefHoldCyc  = 16;
  localparam int unsigned DefStageCyc = 4;
  localparam int unsigned DefQTimeout = 256;

  // One counter width serves hold, stage and timeout so the timer can be shared.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Handshake bundle between the reset sequencer and the rest of the system.
//   usr_req     : user/software reset request (rising edge = request)
//   quiesce_ack : core is drained and safe to reset
//   quiesce_req : sequencer asks the core to drain
//   dom_rstn    : per-domain active-low resets, bit 0 released first
//   running     : all domains released
//   rst_cause   : 00 sys, 01 user-acked, 10 user-timeout
// N_DOM must match the N_DOM of the attached rst_seq.
interface rst_seq_if #(
  parameter int unsigned N_DOM = 3
) ();

  logic             usr_req;
  logic             quiesce_ack;
  logic             quiesce_req;
  logic [N_DOM-1:0] dom_rstn;
  logic             running;
  logic [1:0]       rst_cause;

  modport slave (
    input  usr_req,
    input  quiesce_ack,
    output quiesce_req,
    output dom_rstn,
    output running,
    output rst_cause
  );

  modport master (
    output usr_req,
    output quiesce_ack,
    input  quiesce_req,
    input  dom_rstn,
    input  running,
    input  rst_cause
  );

endinterface

// File: rtl/rst_seq_timer.sv
// Loadable saturating down-counter with a zero flag.
//   clk, rst : clock and synchronous active-high reset (clears the count)
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value to load
//   zero     : count is zero; the counter stops there instead of wrapping
module rst_seq_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer. Holds all domains in reset, releases them one by one
// (domain 0 first), and on a user request drains the core (quiesce handshake
// with timeout) before re-entering reset.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : rst_seq_if slave modport (usr_req, quiesce_ack in; dom_rstn,
//         quiesce_req, running, rst_cause out, all registered)
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned N_DOM     = DefNDom,
  parameter int unsigned HOLD_CYC  = DefHoldCyc,
  parameter int unsigned STAGE_CYC = DefStageCyc,
  parameter int unsigned Q_TIMEOUT = DefQTimeout
) (
  input logic     clk,
  input logic     rst,
  rst_seq_if.slave bus
);

  localparam int unsigned CntW = cnt_width(HOLD_CYC, STAGE_CYC, Q_TIMEOUT);
  // Loading N-1 makes the zero flag fire on the Nth cycle after the load.
  localparam logic [CntW-1:0] HoldLoad  = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] StageLoad = CntW'(STAGE_CYC - 1);
  localparam logic [CntW-1:0] QLoad     = CntW'(Q_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [N_DOM-1:0] dom_rstn_q, dom_rstn_d;
  logic             quiesce_req_q, quiesce_req_d;
  logic             running_q;
  cause_e           cause_q, cause_d;
  // Clear after rst: the first ASSERT cycle with rst low loads the hold count.
  logic             armed_q, armed_d;
  logic             usr_q;

  logic             tmr_load;
  logic [CntW-1:0]  tmr_val;
  logic             tmr_zero;
  logic [N_DOM:0]   dom_ext;
  logic [N_DOM-1:0] dom_shift;

  rst_seq_timer #(
    .W(CntW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

  // Thermometer shift: releases the next domain in order.
  assign dom_ext   = {dom_rstn_q, 1'b1};
  assign dom_shift = dom_ext[N_DOM-1:0];

  always_comb begin
    state_d       = state_q;
    dom_rstn_d    = dom_rstn_q;
    quiesce_req_d = quiesce_req_q;
    cause_d       = cause_q;
    armed_d       = armed_q;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    unique case (state_q)
      StAssert: begin
        dom_rstn_d    = '0;
        quiesce_req_d = 1'b0;
        if (!armed_q) begin
          tmr_load = 1'b1;
          tmr_val  = HoldLoad;
          armed_d  = 1'b1;
        end else if (tmr_zero) begin
          dom_rstn_d[0] = 1'b1;
          tmr_load      = 1'b1;
          tmr_val       = StageLoad;
          state_d       = (N_DOM == 1) ? StRun : StRelease;
        end
      end
      StRelease: begin
        if (tmr_zero) begin
          dom_rstn_d = dom_shift;
          tmr_load   = 1'b1;
          tmr_val    = StageLoad;
          if (&dom_shift) state_d = StRun;
        end
      end
      StRun: begin
        if (bus.usr_req && !usr_q) begin
          state_d       = StQuiesce;
          quiesce_req_d = 1'b1;
          tmr_load      = 1'b1;
          tmr_val       = QLoad;
        end
      end
      StQuiesce: begin
        // Ack wins over a timeout landing in the same cycle.
        if (bus.quiesce_ack || tmr_zero) begin
          state_d       = StAssert;
          dom_rstn_d    = '0;
          quiesce_req_d = 1'b0;
          cause_d       = bus.quiesce_ack ? CauseUserAck : CauseUserTimeout;
          tmr_load      = 1'b1;
          tmr_val       = HoldLoad;
          armed_d       = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StAssert;
      dom_rstn_q    <= '0;
      quiesce_req_q <= 1'b0;
      running_q     <= 1'b0;
      cause_q       <= CauseSys;
      armed_q       <= 1'b0;
      // Preset high so a level held across reset is not seen as an edge.
      usr_q         <= 1'b1;
    end else begin
      state_q       <= state_d;
      dom_rstn_q    <= dom_rstn_d;
      quiesce_req_q <= quiesce_req_d;
      running_q     <= (state_d == StRun);
      cause_q       <= cause_d;
      armed_q       <= armed_d;
      // Sampled in every state so edges outside RUN are consumed, not queued.
      usr_q         <= bus.usr_req;
    end
  end

  assign bus.dom_rstn    = dom_rstn_q;
  assign bus.quiesce_req = quiesce_req_q;
  assign bus.running     = running_q;
  assign bus.rst_cause   = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
module tb_rst_seq;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rst_seq_if #(.N_DOM(3)) bus ();

  rst_seq #(
    .N_DOM    (3),
    .HOLD_CYC (16),
    .STAGE_CYC(4),
    .Q_TIMEOUT(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int dom, input int run, input int qreq,
                           input int cause);
    check({tag, ".dom_rstn"}, 32'(bus.dom_rstn), dom);
    check({tag, ".running"}, 32'(bus.running), run);
    check({tag, ".quiesce_req"}, 32'(bus.quiesce_req), qreq);
    check({tag, ".rst_cause"}, 32'(bus.rst_cause), cause);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    bus.usr_req     = 1'b0;
    bus.quiesce_ack = 1'b0;

    // Power-up: 5 cycles of rst, then 16 hold cycles and staged release.
    step(5);
    check_out("por_reset", 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      check("por_hold", 32'(bus.dom_rstn), 0);
    end
    step(1);
    check_out("por_d0", 1, 0, 0, 0);
    step(3);
    check("por_d0_hold", 32'(bus.dom_rstn), 1);
    step(1);
    check_out("por_d1", 3, 0, 0, 0);
    step(3);
    check_out("por_d1_hold", 3, 0, 0, 0);
    step(1);
    check_out("por_run", 7, 1, 0, 0);

    // Acked user reset: ack sampled 10 cycles after quiesce_req rises.
    step(2);
    bus.usr_req = 1'b1;
    step(1);
    check_out("ack_q0", 7, 0, 1, 0);
    step(9);
    check_out("ack_q9", 7, 0, 1, 0);
    bus.quiesce_ack = 1'b1;
    step(1);
    check_out("ack_assert", 0, 0, 0, 1);
    bus.quiesce_ack = 1'b0;
    bus.usr_req     = 1'b0;
    step(15);
    check("ack_hold", 32'(bus.dom_rstn), 0);
    step(1);
    check("ack_d0", 32'(bus.dom_rstn), 1);
    step(4);
    check("ack_d1", 32'(bus.dom_rstn), 3);
    step(4);
    check_out("ack_run", 7, 1, 0, 1);

    // quiesce_ack outside QUIESCE has no effect.
    bus.quiesce_ack = 1'b1;
    step(3);
    check_out("ack_ignored", 7, 1, 0, 1);
    bus.quiesce_ack = 1'b0;

    // Timeout: ASSERT exactly 256 cycles after quiesce_req rises.
    step(1);
    bus.usr_req = 1'b1;
    step(1);
    check_out("to_q0", 7, 0, 1, 1);
    bus.usr_req = 1'b0;
    step(255);
    check_out("to_q255", 7, 0, 1, 1);
    step(1);
    check_out("to_assert", 0, 0, 0, 2);
    step(24);
    check_out("to_run", 7, 1, 0, 2);

    // Collision: ack arrives on the timeout cycle, ack wins.
    bus.usr_req = 1'b1;
    step(1);
    check_out("col_q0", 7, 0, 1, 2);
    bus.usr_req = 1'b0;
    step(255);
    check("col_q255", 32'(bus.quiesce_req), 1);
    bus.quiesce_ack = 1'b1;
    step(1);
    check_out("col_assert", 0, 0, 0, 1);
    bus.quiesce_ack = 1'b0;
    step(24);
    check_out("col_run", 7, 1, 0, 1);

    // Abort: rst pulse while dom_rstn=011 restarts the full sequence.
    rst = 1'b1;
    step(1);
    check_out("abort_rst", 0, 0, 0, 0);
    rst = 1'b0;
    step(17);
    check("abort_pre_d0", 32'(bus.dom_rstn), 1);
    step(4);
    check("abort_pre_d1", 32'(bus.dom_rstn), 3);
    rst = 1'b1;
    step(1);
    check_out("abort_hit", 0, 0, 0, 0);
    rst = 1'b0;
    step(16);
    check("abort_rehold", 32'(bus.dom_rstn), 0);
    step(1);
    check("abort_re_d0", 32'(bus.dom_rstn), 1);
    step(8);
    check_out("abort_run", 7, 1, 0, 0);

    // usr_req held through reset and toggled during RELEASE is ignored.
    rst         = 1'b1;
    bus.usr_req = 1'b1;
    step(2);
    rst = 1'b0;
    step(16);
    check("held_hold", 32'(bus.dom_rstn), 0);
    step(1);
    check("held_d0", 32'(bus.dom_rstn), 1);
    bus.usr_req = 1'b0;
    step(1);
    bus.usr_req = 1'b1;
    step(1);
    bus.usr_req = 1'b0;
    step(1);
    bus.usr_req = 1'b1;
    step(1);
    check_out("held_d1", 3, 0, 0, 0);
    step(4);
    check_out("held_run", 7, 1, 0, 0);
    step(3);
    check_out("held_no_q", 7, 1, 0, 0);
    bus.usr_req = 1'b0;
    step(1);
    bus.usr_req = 1'b1;
    step(1);
    check_out("held_fresh", 7, 0, 1, 0);
    bus.quiesce_ack = 1'b1;
    step(1);
    check_out("held_ack", 0, 0, 0, 1);
    bus.quiesce_ack = 1'b0;
    bus.usr_req     = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter N_DOM, default 3: number of sequenced reset domains; domain 0 is released first.
REQ-002 SHALL have parameter HOLD_CYC, default 16: cycles all domains stay in reset after reset entry.
REQ-003 SHALL have parameter STAGE_CYC, default 4: cycles between release of domain k-1 and domain k.
REQ-004 SHALL have parameter Q_TIMEOUT, default 256: maximum cycles spent waiting for quiesce_ack.
REQ-005 SHALL have port clk  in  1  the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port usr_req  in  1  user/software reset request; a rising edge is a request.
REQ-008 SHALL have port quiesce_ack  in  1  core reports it is drained and safe to reset.
REQ-009 SHALL have port dom_rstn  out  N_DOM  per-domain active-low reset; bit k drives domain k.
REQ-010 SHALL have port quiesce_req  out  1  asks the core to drain before a user reset.
REQ-011 SHALL have port running  out  1  high only when all domains are released (state RUN).
REQ-012 SHALL have port rst_cause  out  2  cause of the last reset: 00 sys, 01 user-acked, 10 user-timeout.

Function
REQ-013 SHALL implement the states ASSERT, RELEASE, RUN and QUIESCE.
REQ-014 SHALL, in ASSERT, drive dom_rstn all-zero, count HOLD_CYC cycles, then enter RELEASE with stage index 0.
REQ-015 SHALL, on entry to RELEASE, set dom_rstn[0]; every STAGE_CYC cycles it sets the next bit, in order 0..N_DOM-1.
REQ-016 SHALL enter RUN and raise running in the same cycle dom_rstn[N_DOM-1] rises.
REQ-017 SHALL, with defaults, give dom_rstn[0], [1], [2] rising 16, 20 and 24 cycles after the first cycle rst is sampled low.
REQ-018 SHALL keep a released dom_rstn bit high until the next entry into ASSERT (no re-assertion during RELEASE).
REQ-019 SHALL, in RUN, register usr_req and detect a rising edge; on that edge it enters QUIESCE with quiesce_req=1 on the next cycle.
REQ-020 SHALL hold dom_rstn all-ones and quiesce_req high in QUIESCE, and count cycles from entry.
REQ-021 SHALL, in QUIESCE, enter ASSERT with rst_cause=01 when quiesce_ack is sampled high.
REQ-022 SHALL, in QUIESCE, enter ASSERT with rst_cause=10 when Q_TIMEOUT cycles elapse without quiesce_ack.
REQ-023 SHALL give quiesce_ack priority (rst_cause=01) when it arrives in the same cycle as the timeout.
REQ-024 SHALL drop quiesce_req in the cycle ASSERT is entered.
REQ-025 SHALL ignore usr_req edges in ASSERT, RELEASE and QUIESCE; no request is queued.
REQ-026 SHALL ignore quiesce_ack outside QUIESCE.
REQ-027 SHALL make a level-high usr_req held across reset release produce no request until it falls and rises again.
REQ-028 SHALL size all counters as $clog2(max(HOLD_CYC, STAGE_CYC, Q_TIMEOUT)+1) bits, saturating and never wrapping.
REQ-029 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.

Reset
REQ-030 SHALL, on rst=1 in any state, enter ASSERT next cycle with dom_rstn=0, quiesce_req=0, running=0, counters=0, usr_req edge register=1.
REQ-031 SHALL set rst_cause=00 on rst and otherwise hold it until the next user-initiated reset.
REQ-032 SHALL let rst asserted mid-RELEASE or mid-QUIESCE abort the sequence immediately, and restart the full hold and release sequence after rst falls.

Structure
REQ-033 SHALL place the state enum, rst_cause codes and parameter defaults in shared package rst_seq_pkg.
REQ-034 SHALL use one sub-module, rst_seq_timer: a loadable saturating down-counter with a zero flag, reused for hold, stage and timeout.

Verification
REQ-035 SHALL test power-up: rst high 5 cycles then low -> dom_rstn 000 for 16 cycles, then 001, 011 at +4, 111 at +8; running=1 with 111; rst_cause=00.
REQ-036 SHALL test acked user reset: usr_req rising edge in RUN, quiesce_ack high 10 cycles later -> quiesce_req high for those cycles, then dom_rstn=000, full re-release, rst_cause=01.
REQ-037 SHALL test timeout: usr_req edge, quiesce_ack tied low -> ASSERT entered exactly 256 cycles after quiesce_req rises, rst_cause=10.
REQ-038 SHALL test a collision: quiesce_ack rising on the timeout cycle -> rst_cause=01.
REQ-039 SHALL test abort: rst pulsed high 1 cycle while dom_rstn=011 -> next cycle dom_rstn=000, running=0, release restarts from 16 cycles.
REQ-040 SHALL test usr_req held high through power-up and toggled during RELEASE -> no QUIESCE entry; the first fresh edge in RUN is accepted.
